// File: rtl/rotate_pkg.sv
// rotate_pkg: types, angle constants and {phase, q, i} packing shared by derotate_ctrl and the CORDIC rotator
package rotate_pkg;
  localparam int WIDTH = 16;
  typedef logic [WIDTH-1:0] amp_t;
  typedef logic [2*WIDTH-1:0] arg_t;
  localparam arg_t PI = arg_t'(1) << (2*WIDTH-1);
  localparam arg_t PI_2 = arg_t'(1) << (2*WIDTH-2);
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic [4*WIDTH-1:0] pack_word(arg_t phase, amp_t q, amp_t i);
    return {phase, q, i};
  endfunction
endpackage

// File: rtl/derotate_ctrl_nco_acc.sv
// nco_acc: phase accumulator holding the phase of the next accepted sample; load wins over step
module nco_acc
  import rotate_pkg::*;
(
  input  logic clk,
  input  logic reset_n,
  input  logic i_load,
  input  arg_t i_load_val,
  input  logic i_step,
  input  arg_t i_inc,
  output arg_t o_acc
);
  arg_t r_acc;
  assign o_acc = r_acc;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) r_acc <= '0;
    else if (i_load) r_acc <= i_load_val;
    else if (i_step) r_acc <= r_acc + i_inc;
endmodule

// File: rtl/derotate_ctrl.sv
// derotate_ctrl: tags samples with a frame-aligned NCO phase for the rotator; config applies only at frame boundaries.
// Define DEROTATE_CTRL_PHASE_EN to add cfg_phase (per-frame initial phase); otherwise frames start at phase 0.
module derotate_ctrl
  import rotate_pkg::*;
#(
  parameter int WIDTH = rotate_pkg::WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [2*WIDTH-1:0] cfg_freq,
`ifdef DEROTATE_CTRL_PHASE_EN
  input  logic [2*WIDTH-1:0] cfg_phase,
`endif
  input  logic               s_valid,
  output logic               s_ready,
  input  logic               s_last,
  input  logic [2*WIDTH-1:0] s_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic [4*WIDTH-1:0] m_data,
  output logic               busy
);
  state_t r_state;
  arg_t r_freq, r_pend_freq, w_init, w_pend_init, w_acc;
  logic r_pend_valid, r_m_valid, r_m_last;
  logic [4*WIDTH-1:0] r_m_data;
  logic w_s_hs, w_cfg_hs, w_apply;
  assign s_ready = !r_m_valid || m_ready;
  assign w_s_hs = s_valid && s_ready;
  assign cfg_ready = !r_pend_valid;
  assign w_cfg_hs = cfg_valid && cfg_ready;
  assign busy = r_state == RUN;
  assign m_valid = r_m_valid;
  assign m_last = r_m_last;
  assign m_data = r_m_data;
  // pend_valid is registered, so a config can never apply in the cycle it is accepted
  assign w_apply = r_pend_valid && ((r_state == IDLE && !w_s_hs) || (w_s_hs && s_last));
`ifdef DEROTATE_CTRL_PHASE_EN
  arg_t r_init, r_pend_init;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_init <= '0;
      r_pend_init <= '0;
    end else begin
      if (w_cfg_hs) r_pend_init <= cfg_phase;
      if (w_apply) r_init <= r_pend_init;
    end
  assign w_init = r_init;
  assign w_pend_init = r_pend_init;
`else
  assign w_init = '0;
  assign w_pend_init = '0;
`endif
  nco_acc u_nco (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_apply || (w_s_hs && s_last)),
    .i_load_val(w_apply ? w_pend_init : w_init),
    .i_step    (w_s_hs),
    .i_inc     (r_freq),
    .o_acc     (w_acc)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      r_state <= IDLE;
      r_freq <= '0;
      r_pend_freq <= '0;
      r_pend_valid <= 1'b0;
      r_m_valid <= 1'b0;
      r_m_last <= 1'b0;
      r_m_data <= '0;
    end else begin
      if (w_s_hs) r_state <= s_last ? IDLE : RUN;
      if (w_cfg_hs) begin
        r_pend_freq <= cfg_freq;
        r_pend_valid <= 1'b1;
      end else if (w_apply) r_pend_valid <= 1'b0;
      if (w_apply) r_freq <= r_pend_freq;
      if (s_ready) r_m_valid <= s_valid;
      if (w_s_hs) begin
        r_m_data <= pack_word(w_acc, s_data[2*WIDTH-1:WIDTH], s_data[WIDTH-1:0]);
        r_m_last <= s_last;
      end
    end
endmodule
